// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: 4-way intersection phase controller with clearance, pedestrian walk and night flash
module traffic_phase_sequencer #(
  parameter int CNT_W      = 16,
  parameter int T_LEFT     = 15,
  parameter int T_STRAIGHT = 30,
  parameter int T_YELLOW   = 5,
  parameter int T_ALLRED   = 2,
  parameter int T_PED      = 20,
  parameter int T_FLASH    = 1,
  parameter int LEFT_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode_flash,
  input  logic             ped_req,
  output logic [3:0]       traffic_phase,
  output logic [CNT_W-1:0] phase_remaining,
  output logic             phase_start,
  output logic             ped_pending,
  output logic             ped_walk,
  output logic             flash_lamp
);
  localparam logic [3:0] S_LEFT      = 4'd0;
  localparam logic [3:0] N_LEFT      = 4'd1;
  localparam logic [3:0] NS_STRAIGHT = 4'd2;
  localparam logic [3:0] NS_YELLOW   = 4'd3;
  localparam logic [3:0] E_LEFT      = 4'd4;
  localparam logic [3:0] W_LEFT      = 4'd5;
  localparam logic [3:0] EW_STRAIGHT = 4'd6;
  localparam logic [3:0] EW_YELLOW   = 4'd7;
  localparam logic [3:0] ALLRED_A    = 4'd8;
  localparam logic [3:0] ALLRED_B    = 4'd9;
  localparam logic [3:0] PED_WALK    = 4'd10;
  localparam logic [3:0] FLASH       = 4'd11;
  localparam logic [3:0] START       = (LEFT_EN != 0) ? S_LEFT : NS_STRAIGHT;
  localparam longint T_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] TL = CNT_W'(T_LEFT);
  localparam logic [CNT_W-1:0] TS = CNT_W'(T_STRAIGHT);
  localparam logic [CNT_W-1:0] TY = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TA = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] TP = CNT_W'(T_PED);
  localparam logic [CNT_W-1:0] TF = CNT_W'(T_FLASH);

  if (T_LEFT < 1 || T_LEFT > T_MAX || T_STRAIGHT < 1 || T_STRAIGHT > T_MAX ||
      T_YELLOW < 1 || T_YELLOW > T_MAX || T_ALLRED < 1 || T_ALLRED > T_MAX ||
      T_PED < 1 || T_PED > T_MAX || T_FLASH < 1 || T_FLASH > T_MAX) begin : g_bad_timing
    $error("traffic_phase_sequencer: every T_* must be in 1..2^CNT_W-1");
  end

  logic [3:0]       state_q, state_d, nxt;
  logic [CNT_W-1:0] count_q, count_d, t_sel;
  logic             ped_pending_q, ped_pending_d, flash_req_q, flash_req_d;
  logic             flash_lamp_q, flash_lamp_d, phase_start_q, phase_start_d;
  logic             first_q, first_d, done;

  always_comb begin
    t_sel = (state_q inside {S_LEFT, N_LEFT, E_LEFT, W_LEFT}) ? TL :
            (state_q inside {NS_STRAIGHT, EW_STRAIGHT})       ? TS :
            (state_q inside {NS_YELLOW, EW_YELLOW})           ? TY :
            (state_q inside {ALLRED_A, ALLRED_B})             ? TA :
            (state_q == PED_WALK)                             ? TP :
            (state_q == FLASH)                                ? TF : CNT_W'(1);
    done = tick && (count_q == t_sel - CNT_W'(1));
    // flash requests divert left/straight phases to their yellow, clearance phases to FLASH
    case (state_q)
      S_LEFT:      nxt = flash_req_q ? NS_YELLOW : N_LEFT;
      N_LEFT:      nxt = flash_req_q ? NS_YELLOW : NS_STRAIGHT;
      NS_STRAIGHT: nxt = NS_YELLOW;
      NS_YELLOW:   nxt = ALLRED_A;
      ALLRED_A:    nxt = flash_req_q ? FLASH : (LEFT_EN != 0) ? E_LEFT : EW_STRAIGHT;
      E_LEFT:      nxt = flash_req_q ? EW_YELLOW : W_LEFT;
      W_LEFT:      nxt = flash_req_q ? EW_YELLOW : EW_STRAIGHT;
      EW_STRAIGHT: nxt = EW_YELLOW;
      EW_YELLOW:   nxt = ALLRED_B;
      ALLRED_B:    nxt = flash_req_q ? FLASH : ped_pending_q ? PED_WALK : START;
      PED_WALK:    nxt = flash_req_q ? FLASH : START;
      default:     nxt = START;
    endcase
    state_d = (rst || state_q > FLASH) ? START :
              (state_q == FLASH)       ? (mode_flash ? FLASH : ALLRED_B) :
              done                     ? nxt : state_q;
    count_d = (rst || done || state_d != state_q) ? '0 : tick ? count_q + CNT_W'(1) : count_q;
    ped_pending_d = rst ? 1'b0 :
                    (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 :
                    (ped_req && state_q != PED_WALK) ? 1'b1 : ped_pending_q;
    flash_req_d   = !rst && mode_flash;
    flash_lamp_d  = (!rst && state_q == FLASH && state_d == FLASH) ? (flash_lamp_q ^ done) : 1'b0;
    first_d       = rst;
    phase_start_d = !rst && (first_q || state_d != state_q);
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    count_q       <= count_d;
    ped_pending_q <= ped_pending_d;
    flash_req_q   <= flash_req_d;
    flash_lamp_q  <= flash_lamp_d;
    phase_start_q <= phase_start_d;
    first_q       <= first_d;
  end

  assign traffic_phase   = state_q;
  assign phase_remaining = (state_q == FLASH) ? '0 : t_sel - count_q;
  assign phase_start     = phase_start_q;
  assign ped_pending     = ped_pending_q;
  assign ped_walk        = (state_q == PED_WALK);
  assign flash_lamp      = flash_lamp_q;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed checks of ring timing, tick gating, pedestrian, flash, left skip and reset
module tb_traffic_phase_sequencer;
  logic        clk = 0, rst = 1, tick = 1, mode_flash = 0, ped_req = 0;
  logic [3:0]  traffic_phase, tp0;
  logic [15:0] phase_remaining, rem0;
  logic        phase_start, ped_pending, ped_walk, flash_lamp;
  logic        ps0, pp0, pw0, fl0;
  int checks = 0, passed = 0;
  int seq1[$], seq0[$];

  traffic_phase_sequencer #(.CNT_W(16), .T_LEFT(3), .T_STRAIGHT(4), .T_YELLOW(2), .T_ALLRED(1),
    .T_PED(3), .T_FLASH(2), .LEFT_EN(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_flash(mode_flash), .ped_req(ped_req),
    .traffic_phase(traffic_phase), .phase_remaining(phase_remaining), .phase_start(phase_start),
    .ped_pending(ped_pending), .ped_walk(ped_walk), .flash_lamp(flash_lamp));

  traffic_phase_sequencer #(.CNT_W(16), .T_LEFT(3), .T_STRAIGHT(4), .T_YELLOW(2), .T_ALLRED(1),
    .T_PED(3), .T_FLASH(2), .LEFT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .mode_flash(mode_flash), .ped_req(ped_req),
    .traffic_phase(tp0), .phase_remaining(rem0), .phase_start(ps0),
    .ped_pending(pp0), .ped_walk(pw0), .flash_lamp(fl0));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; tick = 1; ped_req = 0; mode_flash = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick = 1; ped_req = 0; mode_flash = 0;
    step();
    step();
    checks++; if (traffic_phase !== 4'd0) $display("FAIL reset_phase got %0d want 0", traffic_phase); else passed++;
    checks++; if (phase_remaining !== 16'd3) $display("FAIL reset_remaining got %0d want 3", phase_remaining); else passed++;
    checks++; if (phase_start !== 1'b0) $display("FAIL reset_phase_start got %0b want 0", phase_start); else passed++;
    checks++; if (ped_pending !== 1'b0) $display("FAIL reset_ped_pending got %0b want 0", ped_pending); else passed++;
    checks++; if (flash_lamp !== 1'b0) $display("FAIL reset_flash_lamp got %0b want 0", flash_lamp); else passed++;
    checks++; if (ped_walk !== 1'b0) $display("FAIL reset_ped_walk got %0b want 0", ped_walk); else passed++;
    checks++; if (tp0 !== 4'd2) $display("FAIL reset_phase_noleft got %0d want 2", tp0); else passed++;
  endtask

  task automatic test_ring();
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      checks++;
      if (traffic_phase !== 4'(seq1[c % 26])) $display("FAIL ring_phase c=%0d got %0d want %0d", c, traffic_phase, seq1[c % 26]);
      else passed++;
      if (c < 3) begin
        checks++;
        if (phase_remaining !== 16'(3 - c)) $display("FAIL ring_remaining c=%0d got %0d want %0d", c, phase_remaining, 3 - c);
        else passed++;
      end
      if (c >= 2) begin
        checks++;
        if (phase_start !== 1'(seq1[c % 26] != seq1[c - 1])) $display("FAIL ring_phase_start c=%0d got %0b want %0b", c, phase_start, seq1[c % 26] != seq1[c - 1]);
        else passed++;
      end
      step();
    end
  endtask

  task automatic test_tick();
    do_reset();
    for (int c = 0; c < 78; c++) begin
      checks++;
      if (traffic_phase !== 4'(seq1[(c / 3) % 26])) $display("FAIL tick_phase c=%0d got %0d want %0d", c, traffic_phase, seq1[(c / 3) % 26]);
      else passed++;
      tick = ((c + 1) % 3 == 0);
      step();
    end
    tick = 1;
    do_reset();
    repeat (7) step();
    checks++; if (traffic_phase !== 4'd2) $display("FAIL hold_pre_phase got %0d want 2", traffic_phase); else passed++;
    checks++; if (phase_remaining !== 16'd3) $display("FAIL hold_pre_remaining got %0d want 3", phase_remaining); else passed++;
    tick = 0;
    repeat (100) step();
    checks++; if (traffic_phase !== 4'd2) $display("FAIL hold_phase got %0d want 2", traffic_phase); else passed++;
    checks++; if (phase_remaining !== 16'd3) $display("FAIL hold_remaining got %0d want 3", phase_remaining); else passed++;
    tick = 1;
  endtask

  task automatic test_ped();
    do_reset();
    repeat (13) step();
    checks++; if (traffic_phase !== 4'd4) $display("FAIL ped_eleft got %0d want 4", traffic_phase); else passed++;
    ped_req = 1;
    step();
    ped_req = 0;
    checks++; if (ped_pending !== 1'b1) $display("FAIL ped_latched got %0b want 1", ped_pending); else passed++;
    repeat (11) step();
    checks++; if (traffic_phase !== 4'd9) $display("FAIL ped_allred_b got %0d want 9", traffic_phase); else passed++;
    checks++; if (ped_pending !== 1'b1) $display("FAIL ped_held got %0b want 1", ped_pending); else passed++;
    step();
    checks++; if (traffic_phase !== 4'd10) $display("FAIL ped_walk_phase got %0d want 10", traffic_phase); else passed++;
    checks++; if (ped_walk !== 1'b1) $display("FAIL ped_walk got %0b want 1", ped_walk); else passed++;
    checks++; if (ped_pending !== 1'b0) $display("FAIL ped_cleared got %0b want 0", ped_pending); else passed++;
    checks++; if (phase_start !== 1'b1) $display("FAIL ped_start got %0b want 1", phase_start); else passed++;
    step();
    step();
    checks++; if (traffic_phase !== 4'd10) $display("FAIL ped_walk_last got %0d want 10", traffic_phase); else passed++;
    checks++; if (phase_remaining !== 16'd1) $display("FAIL ped_remaining got %0d want 1", phase_remaining); else passed++;
    step();
    checks++; if (traffic_phase !== 4'd0) $display("FAIL ped_exit got %0d want 0", traffic_phase); else passed++;
    checks++; if (ped_walk !== 1'b0) $display("FAIL ped_walk_off got %0b want 0", ped_walk); else passed++;
  endtask

  task automatic test_flash();
    do_reset();
    repeat (6) step();
    mode_flash = 1;
    repeat (3) step();
    checks++; if (traffic_phase !== 4'd2) $display("FAIL flash_straight_kept got %0d want 2", traffic_phase); else passed++;
    step();
    checks++; if (traffic_phase !== 4'd3) $display("FAIL flash_yellow got %0d want 3", traffic_phase); else passed++;
    step();
    step();
    checks++; if (traffic_phase !== 4'd8) $display("FAIL flash_allred got %0d want 8", traffic_phase); else passed++;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (traffic_phase !== 4'd11) $display("FAIL flash_phase i=%0d got %0d want 11", i, traffic_phase); else passed++;
      checks++;
      if (flash_lamp !== 1'((i / 2) % 2)) $display("FAIL flash_lamp i=%0d got %0b want %0b", i, flash_lamp, (i / 2) % 2); else passed++;
      checks++;
      if (phase_remaining !== 16'd0) $display("FAIL flash_remaining i=%0d got %0d want 0", i, phase_remaining); else passed++;
      if (i < 5) step();
    end
    mode_flash = 0;
    step();
    checks++; if (traffic_phase !== 4'd9) $display("FAIL flash_exit got %0d want 9", traffic_phase); else passed++;
    checks++; if (flash_lamp !== 1'b0) $display("FAIL flash_lamp_off got %0b want 0", flash_lamp); else passed++;
    step();
    checks++; if (traffic_phase !== 4'd0) $display("FAIL flash_resume got %0d want 0", traffic_phase); else passed++;
  endtask

  task automatic test_left_skip();
    do_reset();
    for (int c = 0; c < 28; c++) begin
      checks++;
      if (tp0 !== 4'(seq0[c % 14])) $display("FAIL noleft_phase c=%0d got %0d want %0d", c, tp0, seq0[c % 14]);
      else passed++;
      step();
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    ped_req = 1;
    step();
    ped_req = 0;
    repeat (19) step();
    checks++; if (traffic_phase !== 4'd6) $display("FAIL mid_phase got %0d want 6", traffic_phase); else passed++;
    checks++; if (ped_pending !== 1'b1) $display("FAIL mid_ped_pending got %0b want 1", ped_pending); else passed++;
    rst = 1; tick = 0;
    step();
    checks++; if (traffic_phase !== 4'd0) $display("FAIL mid_rst_phase got %0d want 0", traffic_phase); else passed++;
    checks++; if (ped_pending !== 1'b0) $display("FAIL mid_rst_ped got %0b want 0", ped_pending); else passed++;
    checks++; if (flash_lamp !== 1'b0) $display("FAIL mid_rst_lamp got %0b want 0", flash_lamp); else passed++;
    rst = 0; tick = 1;
    step();
    force dut.state_q = 4'd13;
    #1;
    release dut.state_q;
    step();
    checks++; if (traffic_phase !== 4'd0) $display("FAIL illegal_recover got %0d want 0", traffic_phase); else passed++;
  endtask

  initial begin
    int c1[10] = '{0, 1, 2, 3, 8, 4, 5, 6, 7, 9};
    int d1[10] = '{3, 3, 4, 2, 1, 3, 3, 4, 2, 1};
    int c0[6]  = '{2, 3, 8, 6, 7, 9};
    int d0[6]  = '{4, 2, 1, 4, 2, 1};
    for (int i = 0; i < 10; i++) for (int j = 0; j < d1[i]; j++) seq1.push_back(c1[i]);
    for (int i = 0; i < 6; i++) for (int j = 0; j < d0[i]; j++) seq0.push_back(c0[i]);
    test_reset();
    test_ring();
    test_tick();
    test_ped();
    test_flash();
    test_left_skip();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
